// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-source round-robin transmit scheduler.
// One source is granted per frame. Its payload bytes are streamed into the transmit byte FIFO.
// A single frame-info word {source, length} is written after the last byte, so the transmit
// side never sees a partially written frame.
module eth_tx_sched #(
   parameter int MAX_LEN = 1500,
   parameter int MIN_LEN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        aReq,
   input  logic [10:0] aLen,
   output logic        aAck,
   input  logic [7:0]  aData,
   input  logic        aValid,
   output logic        aReady,
   input  logic        bReq,
   input  logic [10:0] bLen,
   output logic        bAck,
   input  logic [7:0]  bData,
   input  logic        bValid,
   output logic        bReady,
   output logic [7:0]  txFifoIn,
   output logic        txWrEn,
   input  logic        txFifoFull,
   output logic [11:0] tfFifoIn,
   output logic        tfWrEn,
   input  logic        tfFifoFull,
   output logic        busy,
   output logic        lenErr,
   output logic [15:0] frameCnt
);

   localparam logic [10:0] minLen = 11'(MIN_LEN);
   localparam logic [10:0] maxLen = 11'(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      INFO   = 2'd2
   } stateT;

   stateT       state;
   stateT       stateNext;
   logic        sel;        // granted source: 0 = A, 1 = B
   logic        lastGrant;  // last winner, 1 = B
   logic [10:0] lenR;
   logic [10:0] cnt;
   logic [15:0] frameCntR;
   logic        aAckR;
   logic        bAckR;
   logic        lenErrR;

   logic        arbEn;
   logic        grantA;
   logic        grantB;
   logic        grantAny;
   logic [10:0] grantLen;
   logic        lenOk;
   logic        selValid;
   logic [7:0]  selData;
   logic        byteAcc;
   logic        lastByte;
   logic        infoWr;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Arbitration, byte acceptance and next-state decode
   always_comb begin
      stateNext = state;
      // While an ack pulse is out, the requester may still hold its request for this cycle.
      // Arbitration is held off so that a rejected request cannot be granted twice.
      arbEn    = (state == IDLE) && !aAckR && !bAckR;
      grantA   = arbEn && aReq && (!bReq || lastGrant);
      grantB   = arbEn && bReq && !grantA;
      grantAny = grantA || grantB;
      grantLen = grantB ? bLen : aLen;
      lenOk    = (grantLen >= minLen) && (grantLen <= maxLen);
      selValid = sel ? bValid : aValid;
      selData  = sel ? bData : aData;
      byteAcc  = (state == STREAM) && selValid && !txFifoFull;
      lastByte = byteAcc && (cnt == (lenR - 11'd1));
      infoWr   = (state == INFO) && !tfFifoFull;
      case (state)
         IDLE: begin
            if (grantAny && lenOk) begin
               stateNext = STREAM;
            end else begin
               stateNext = IDLE;
            end
         end
         STREAM: begin
            if (lastByte) begin
               stateNext = INFO;
            end else begin
               stateNext = STREAM;
            end
         end
         INFO: begin
            if (infoWr) begin
               stateNext = IDLE;
            end else begin
               stateNext = INFO;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Grant bookkeeping, byte counter, ack/error pulses and the frame counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel       <= 1'b0;
         lastGrant <= 1'b1;
         lenR      <= 11'd0;
         cnt       <= 11'd0;
         frameCntR <= 16'd0;
         aAckR     <= 1'b0;
         bAckR     <= 1'b0;
         lenErrR   <= 1'b0;
      end else begin
         aAckR   <= grantA;
         bAckR   <= grantB;
         lenErrR <= grantAny && !lenOk;
         if (grantAny) begin
            sel       <= grantB;
            lastGrant <= grantB;
            lenR      <= grantLen;
            cnt       <= 11'd0;
         end else if (byteAcc) begin
            cnt <= cnt + 11'd1;
         end else begin
            cnt <= cnt;
         end
         if (infoWr) begin
            frameCntR <= frameCntR + 16'd1;
         end else begin
            frameCntR <= frameCntR;
         end
      end
   end

   // Byte path and readies are same-cycle so a full FIFO blocks the write immediately
   assign aReady   = (state == STREAM) && !sel && !txFifoFull;
   assign bReady   = (state == STREAM) && sel && !txFifoFull;
   assign txWrEn   = byteAcc;
   assign txFifoIn = byteAcc ? selData : 8'd0;
   assign tfWrEn   = infoWr;
   assign tfFifoIn = infoWr ? {sel, lenR} : 12'd0;
   assign busy     = (state != IDLE);
   assign aAck     = aAckR;
   assign bAck     = bAckR;
   assign lenErr   = lenErrR;
   assign frameCnt = frameCntR;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: per-cycle vector table for eth_tx_sched plus a back-to-back frame sequence.
module tb_eth_tx_sched;

   typedef struct {
      bit          rst;
      bit          aReq;
      logic [10:0] aLen;
      logic [7:0]  aData;
      bit          aValid;
      bit          bReq;
      logic [10:0] bLen;
      logic [7:0]  bData;
      bit          bValid;
      bit          txF;
      bit          tfF;
      logic [43:0] ex;
   } vecT;

   localparam bit          hi = 1'b1;
   localparam bit          lo = 1'b0;
   localparam logic [10:0] nl = 11'd0;
   localparam logic [7:0]  nd = 8'h00;
   localparam logic [11:0] ni = 12'h000;

   logic        ethTXclock = 1'b0;
   logic        reset;
   logic        aReq, bReq, aValid, bValid, txFifoFull, tfFifoFull;
   logic [10:0] aLen, bLen;
   logic [7:0]  aData, bData;
   logic        aAck, bAck, aReady, bReady, txWrEn, tfWrEn, busy, lenErr;
   logic [7:0]  txFifoIn;
   logic [11:0] tfFifoIn;
   logic [15:0] frameCnt;

   int testsRun = 0;
   int testsFailed = 0;
   vecT vecs[$];

   eth_tx_sched dut (
      .clk(ethTXclock), .reset(reset),
      .aReq(aReq), .aLen(aLen), .aAck(aAck), .aData(aData), .aValid(aValid), .aReady(aReady),
      .bReq(bReq), .bLen(bLen), .bAck(bAck), .bData(bData), .bValid(bValid), .bReady(bReady),
      .txFifoIn(txFifoIn), .txWrEn(txWrEn), .txFifoFull(txFifoFull),
      .tfFifoIn(tfFifoIn), .tfWrEn(tfWrEn), .tfFifoFull(tfFifoFull),
      .busy(busy), .lenErr(lenErr), .frameCnt(frameCnt)
   );

   // Free-running clock
   always #5 ethTXclock = ~ethTXclock;

   function automatic logic [43:0] e(input bit aAk, input bit bAk, input bit aRd, input bit bRd,
                                     input bit txW, input logic [7:0] txI, input bit tfW,
                                     input logic [11:0] tfI, input bit bsy, input bit le,
                                     input logic [15:0] fc);
      return {aAk, bAk, aRd, bRd, txW, txI, tfW, tfI, bsy, le, fc};
   endfunction

   function automatic logic [43:0] idle(input logic [15:0] fc);
      return e(lo, lo, lo, lo, lo, nd, lo, ni, lo, lo, fc);
   endfunction

   function automatic vecT v(input bit rst, input bit aRq, input logic [10:0] aL, input logic [7:0] aD,
                             input bit aV, input bit bRq, input logic [10:0] bL, input logic [7:0] bD,
                             input bit bV, input bit txF, input bit tfF, input logic [43:0] ex);
      vecT r;
      r.rst = rst; r.aReq = aRq; r.aLen = aL; r.aData = aD; r.aValid = aV;
      r.bReq = bRq; r.bLen = bL; r.bData = bD; r.bValid = bV;
      r.txF = txF; r.tfF = tfF; r.ex = ex;
      return r;
   endfunction

   function automatic vecT vz(input bit rst, input logic [43:0] ex);
      return v(rst, lo, nl, nd, lo, lo, nl, nd, lo, lo, lo, ex);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [43:0] act;
      int writes;
      bit done;

      // Single frame A, length 4
      vecs.push_back(vz(hi, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd4, 8'h11, hi, lo, nl, nd, lo, lo, lo, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd4, 8'h11, hi, lo, nl, nd, lo, lo, lo, e(hi, lo, hi, lo, hi, 8'h11, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd4, 8'h22, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h22, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd4, 8'h33, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h33, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd4, 8'h44, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h44, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd4, nd, lo, lo, nl, nd, lo, lo, lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h004, hi, lo, 16'd0)));
      vecs.push_back(vz(lo, idle(16'd1)));
      // Contention: A, B, A, B with length 2
      vecs.push_back(vz(hi, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd2, 8'hA1, hi, hi, 11'd2, 8'hB1, hi, lo, lo, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd2, 8'hA1, hi, hi, 11'd2, 8'hB1, hi, lo, lo, e(hi, lo, hi, lo, hi, 8'hA1, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd2, 8'hA2, hi, hi, 11'd2, 8'hB1, hi, lo, lo, e(lo, lo, hi, lo, hi, 8'hA2, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd2, nd, lo, hi, 11'd2, 8'hB1, hi, lo, lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h002, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd2, nd, lo, hi, 11'd2, 8'hB1, hi, lo, lo, idle(16'd1)));
      vecs.push_back(v(lo, lo, 11'd2, nd, lo, hi, 11'd2, 8'hB1, hi, lo, lo, e(lo, hi, lo, hi, hi, 8'hB1, lo, ni, hi, lo, 16'd1)));
      vecs.push_back(v(lo, lo, 11'd2, nd, lo, lo, 11'd2, 8'hB2, hi, lo, lo, e(lo, lo, lo, hi, hi, 8'hB2, lo, ni, hi, lo, 16'd1)));
      vecs.push_back(vz(lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h802, hi, lo, 16'd1)));
      vecs.push_back(v(lo, hi, 11'd2, 8'hC1, hi, hi, 11'd2, 8'hD1, hi, lo, lo, idle(16'd2)));
      vecs.push_back(v(lo, hi, 11'd2, 8'hC1, hi, hi, 11'd2, 8'hD1, hi, lo, lo, e(hi, lo, hi, lo, hi, 8'hC1, lo, ni, hi, lo, 16'd2)));
      vecs.push_back(v(lo, lo, 11'd2, 8'hC2, hi, hi, 11'd2, 8'hD1, hi, lo, lo, e(lo, lo, hi, lo, hi, 8'hC2, lo, ni, hi, lo, 16'd2)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd2, 8'hD1, hi, lo, lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h002, hi, lo, 16'd2)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd2, 8'hD1, hi, lo, lo, idle(16'd3)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd2, 8'hD1, hi, lo, lo, e(lo, hi, lo, hi, hi, 8'hD1, lo, ni, hi, lo, 16'd3)));
      vecs.push_back(v(lo, lo, nl, nd, lo, lo, 11'd2, 8'hD2, hi, lo, lo, e(lo, lo, lo, hi, hi, 8'hD2, lo, ni, hi, lo, 16'd3)));
      vecs.push_back(vz(lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h802, hi, lo, 16'd3)));
      vecs.push_back(vz(lo, idle(16'd4)));
      // Back-pressure: txFifoFull for 3 cycles, a valid gap, then tfFifoFull for 2 cycles
      vecs.push_back(v(lo, hi, 11'd3, 8'h51, hi, lo, nl, nd, lo, lo, lo, idle(16'd4)));
      vecs.push_back(v(lo, hi, 11'd3, 8'h51, hi, lo, nl, nd, lo, lo, lo, e(hi, lo, hi, lo, hi, 8'h51, lo, ni, hi, lo, 16'd4)));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(v(lo, lo, 11'd3, 8'h52, hi, lo, nl, nd, lo, hi, lo, e(lo, lo, lo, lo, lo, nd, lo, ni, hi, lo, 16'd4)));
      end
      vecs.push_back(v(lo, lo, 11'd3, 8'h52, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h52, lo, ni, hi, lo, 16'd4)));
      vecs.push_back(v(lo, lo, 11'd3, 8'h53, lo, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, lo, nd, lo, ni, hi, lo, 16'd4)));
      vecs.push_back(v(lo, lo, 11'd3, 8'h53, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h53, lo, ni, hi, lo, 16'd4)));
      for (int k = 0; k < 2; k++) begin
         vecs.push_back(v(lo, lo, nl, nd, lo, lo, nl, nd, lo, lo, hi, e(lo, lo, lo, lo, lo, nd, lo, ni, hi, lo, 16'd4)));
      end
      vecs.push_back(vz(lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h003, hi, lo, 16'd4)));
      vecs.push_back(vz(lo, idle(16'd5)));
      // Illegal lengths on B: 0 and 1501
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd0, nd, lo, lo, lo, idle(16'd5)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd0, nd, lo, lo, lo, e(lo, hi, lo, lo, lo, nd, lo, ni, lo, hi, 16'd5)));
      vecs.push_back(vz(lo, idle(16'd5)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd1501, nd, lo, lo, lo, idle(16'd5)));
      vecs.push_back(v(lo, lo, nl, nd, lo, hi, 11'd1501, nd, lo, lo, lo, e(lo, hi, lo, lo, lo, nd, lo, ni, lo, hi, 16'd5)));
      vecs.push_back(vz(lo, idle(16'd5)));
      // Reset after 2 of 10 bytes, then a 1-byte frame
      vecs.push_back(v(lo, hi, 11'd10, 8'h61, hi, lo, nl, nd, lo, lo, lo, idle(16'd5)));
      vecs.push_back(v(lo, hi, 11'd10, 8'h61, hi, lo, nl, nd, lo, lo, lo, e(hi, lo, hi, lo, hi, 8'h61, lo, ni, hi, lo, 16'd5)));
      vecs.push_back(v(lo, lo, 11'd10, 8'h62, hi, lo, nl, nd, lo, lo, lo, e(lo, lo, hi, lo, hi, 8'h62, lo, ni, hi, lo, 16'd5)));
      vecs.push_back(v(hi, lo, 11'd10, 8'h63, hi, lo, nl, nd, lo, lo, lo, idle(16'd0)));
      vecs.push_back(vz(lo, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd1, 8'h71, hi, lo, nl, nd, lo, lo, lo, idle(16'd0)));
      vecs.push_back(v(lo, hi, 11'd1, 8'h71, hi, lo, nl, nd, lo, lo, lo, e(hi, lo, hi, lo, hi, 8'h71, lo, ni, hi, lo, 16'd0)));
      vecs.push_back(v(lo, lo, 11'd1, nd, lo, lo, nl, nd, lo, lo, lo, e(lo, lo, lo, lo, lo, nd, hi, 12'h001, hi, lo, 16'd0)));
      vecs.push_back(vz(lo, idle(16'd1)));
      // Largest legal length is accepted without lenErr
      vecs.push_back(v(lo, hi, 11'd1500, nd, lo, lo, nl, nd, lo, lo, lo, idle(16'd1)));
      vecs.push_back(v(lo, hi, 11'd1500, nd, lo, lo, nl, nd, lo, lo, lo, e(hi, lo, hi, lo, lo, nd, lo, ni, hi, lo, 16'd1)));
      vecs.push_back(vz(hi, idle(16'd0)));
      vecs.push_back(vz(lo, idle(16'd0)));

      reset = 1'b1;
      aReq = 1'b0; aLen = 11'd0; aData = 8'h00; aValid = 1'b0;
      bReq = 1'b0; bLen = 11'd0; bData = 8'h00; bValid = 1'b0;
      txFifoFull = 1'b0; tfFifoFull = 1'b0;
      repeat (2) @(posedge ethTXclock);

      foreach (vecs[i]) begin
         @(negedge ethTXclock);
         reset = vecs[i].rst;
         aReq = vecs[i].aReq; aLen = vecs[i].aLen; aData = vecs[i].aData; aValid = vecs[i].aValid;
         bReq = vecs[i].bReq; bLen = vecs[i].bLen; bData = vecs[i].bData; bValid = vecs[i].bValid;
         txFifoFull = vecs[i].txF; tfFifoFull = vecs[i].tfF;
         #1;
         act = {aAck, bAck, aReady, bReady, txWrEn, txFifoIn, tfWrEn, tfFifoIn, busy, lenErr, frameCnt};
         check($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].ex));
      end

      // Back-to-back 1-byte frames from A; frameCnt starts at 0 here
      writes = 0;
      for (int f = 0; f < 20; f++) begin
         aReq = 1'b1; aLen = 11'd1; aValid = 1'b1; aData = 8'(f + 8'h80);
         done = 1'b0;
         for (int c = 0; c < 8 && !done; c++) begin
            @(negedge ethTXclock);
            #1;
            if (txWrEn) begin
               writes++;
               check($sformatf("b2b_byte%0d", f), 64'(txFifoIn), 64'(f + 8'h80));
            end
            if (aAck) begin
               aReq = 1'b0;
            end
            if (tfWrEn) begin
               done = 1'b1;
               check($sformatf("b2b_info%0d", f), 64'(tfFifoIn), 64'(12'h001));
            end
         end
         if (!done) begin
            check($sformatf("b2b_timeout%0d", f), 64'(0), 64'(1));
         end
      end
      aReq = 1'b0; aValid = 1'b0;
      @(negedge ethTXclock);
      #1;
      check("b2b_frameCnt", 64'(frameCnt), 64'(16'd20));
      check("b2b_writes", 64'(writes), 64'(20));
      check("b2b_busy", 64'(busy), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
